// File: rtl/xy_modulo_seq.sv
`default_nettype none
// ============================================================================
// xy_modulo_seq : RESULT = X mod (X - Y) via WIDTH-step restoring division;
// optional quotient register enabled by macro XYMOD_QUOTIENT_EN.  Rev 1.0
// ============================================================================
module xy_modulo_seq #(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             E,
   input  logic             W,
   input  logic             R,
   input  logic [2:0]       ADDR,
   input  logic [WIDTH-1:0] D,
   output logic [31:0]      OUT
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DIV  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] x_reg;
   logic [WIDTH-1:0] y_reg;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] div_r;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvd;
   logic [CNT_W-1:0] cnt;
   logic             done;
   logic             dz;
`ifdef XYMOD_QUOTIENT_EN
   logic [WIDTH-1:0] quotient;
`endif

   logic             busy;
   logic             wr_en;
   logic             rd_en;
   logic             start;
   logic             clr;
   logic             x_we;
   logic             y_we;
   logic             last;
   logic [WIDTH-1:0] div_val;
   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   diff;
   logic             ge;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] quo_nxt;
   logic [31:0]      rd_val;

   assign busy    = (state != IDLE);
   assign wr_en   = E & W;
   assign rd_en   = E & R;
   assign start   = wr_en && (ADDR == 3'd3) && D[0] && !busy;
   assign clr     = wr_en && (ADDR == 3'd3) && D[1];
   assign x_we    = wr_en && (ADDR == 3'd0) && !busy;
   assign y_we    = wr_en && (ADDR == 3'd1) && !busy;
   assign last    = (cnt == LAST_CNT);
   assign div_val = x_reg - y_reg;

   // One restoring step: shift the next dividend bit into the partial remainder.
   // dvd shifts left each step, so its low bits collect the quotient MSB first.
   assign trial   = {rem, dvd[WIDTH-1]};
   assign diff    = trial - {1'b0, div_r};
   assign ge      = (trial >= {1'b0, div_r});
   assign rem_nxt = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
   assign quo_nxt = {dvd[WIDTH-2:0], ge};

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            state_nxt = (div_val == '0) ? IDLE : DIV;
         end
         DIV: begin
            if (last) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         x_reg    <= '0;
         y_reg    <= '0;
         result   <= '0;
         div_r    <= '0;
         rem      <= '0;
         dvd      <= '0;
         cnt      <= '0;
         done     <= 1'b0;
         dz       <= 1'b0;
`ifdef XYMOD_QUOTIENT_EN
         quotient <= '0;
`endif
      end else begin
         if (x_we) begin
            x_reg <= D;
         end
         if (y_we) begin
            y_reg <= D;
         end
         if (start || clr) begin
            done <= 1'b0;
            dz   <= 1'b0;
         end
         // Completion is evaluated after the clear so a same-cycle clear cannot hide it.
         case (state)
            LOAD: begin
               div_r <= div_val;
               rem   <= '0;
               dvd   <= x_reg;
               cnt   <= '0;
               if (div_val == '0) begin
                  result   <= x_reg;
                  dz       <= 1'b1;
                  done     <= 1'b1;
`ifdef XYMOD_QUOTIENT_EN
                  quotient <= '1;
`endif
               end
            end
            DIV: begin
               rem <= rem_nxt;
               dvd <= quo_nxt;
               cnt <= cnt + 1'b1;
               if (last) begin
                  result   <= rem_nxt;
                  done     <= 1'b1;
`ifdef XYMOD_QUOTIENT_EN
                  quotient <= quo_nxt;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   // Write-first: a same-cycle accepted write to X/Y returns the incoming data.
   always_comb begin
      rd_val = '0;
      case (ADDR)
         3'd0: rd_val = x_we ? 32'(D) : 32'(x_reg);
         3'd1: rd_val = y_we ? 32'(D) : 32'(y_reg);
         3'd2: rd_val = 32'(result);
         3'd3: rd_val = {29'b0, dz, done, busy};
`ifdef XYMOD_QUOTIENT_EN
         3'd4: rd_val = 32'(quotient);
`else
         3'd4: rd_val = '0;
`endif
         default: rd_val = '0;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         OUT <= '0;
      end else if (rd_en) begin
         OUT <= rd_val;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_xy_modulo_seq.sv
`default_nettype none
// ============================================================================
// tb_xy_modulo_seq : directed self-checking bench for xy_modulo_seq.  Rev 1.0
// ============================================================================
module tb_xy_modulo_seq;

   localparam int WIDTH = 16;
`ifdef XYMOD_QUOTIENT_EN
   localparam logic [31:0] QUO_100_93 = 32'd14;
   localparam logic [31:0] QUO_DZ     = 32'h0000_FFFF;
`else
   localparam logic [31:0] QUO_100_93 = 32'd0;
   localparam logic [31:0] QUO_DZ     = 32'd0;
`endif

   logic             CLK;
   logic             RSTN;
   logic             E;
   logic             W;
   logic             R;
   logic [2:0]       ADDR;
   logic [WIDTH-1:0] D;
   logic [31:0]      OUT;

   int checks;
   int errors;

   xy_modulo_seq #(.WIDTH(WIDTH)) dut (
      .CLK  (CLK),
      .RSTN (RSTN),
      .E    (E),
      .W    (W),
      .R    (R),
      .ADDR (ADDR),
      .D    (D),
      .OUT  (OUT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One bus cycle: drive at negedge, capture at posedge, return OUT just after.
   task automatic xfer(input logic en, input logic we, input logic re,
                       input logic [2:0] a, input logic [31:0] d,
                       output logic [31:0] q);
      @(negedge CLK);
      E    = en;
      W    = we;
      R    = re;
      ADDR = a;
      D    = d[WIDTH-1:0];
      @(posedge CLK);
      #1;
      q = OUT;
      E = 1'b0;
      W = 1'b0;
      R = 1'b0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      logic [31:0] q;
      xfer(1'b1, 1'b1, 1'b0, a, d, q);
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] q);
      xfer(1'b1, 1'b0, 1'b1, a, 32'd0, q);
   endtask

   // Reads STATUS every cycle until BUSY drops; n counts reads that saw BUSY=1.
   task automatic wait_idle(output int n, output logic [31:0] st);
      n = 0;
      rd(3'd3, st);
      while (st[0] && n < 200) begin
         n++;
         rd(3'd3, st);
      end
      if (n >= 200) check("busy_timeout", st, 32'd0);
   endtask

   initial begin
      logic [31:0] q;
      logic [31:0] acc;
      int          n;

      checks = 0;
      errors = 0;
      RSTN = 1'b0;
      E    = 1'b0;
      W    = 1'b0;
      R    = 1'b0;
      ADDR = 3'd0;
      D    = '0;

      #12;
      check("reset_out", OUT, 32'd0);
      @(negedge CLK);
      RSTN = 1'b1;
      for (int a = 0; a < 5; a++) begin
         rd(3'(a), q);
         check($sformatf("reset_reg%0d", a), q, 32'd0);
      end

      // 100 mod 7 = 2, quotient 14
      wr(3'd0, 32'd100);
      wr(3'd1, 32'd93);
      rd(3'd0, q);  check("x_readback", q, 32'd100);
      rd(3'd1, q);  check("y_readback", q, 32'd93);
      wr(3'd3, 32'd1);
      wait_idle(n, q);
      check("busy_cycles", 32'(n), 32'd17);
      check("status_done", q, 32'h2);
      rd(3'd2, q);  check("result_100_93", q, 32'd2);
      rd(3'd4, q);  check("quotient_100_93", q, QUO_100_93);

      // divisor wraps to 65531
      wr(3'd0, 32'd5);
      wr(3'd1, 32'd10);
      wr(3'd3, 32'd1);
      wait_idle(n, q);
      check("status_wrap", q, 32'h2);
      rd(3'd2, q);  check("result_wrap", q, 32'd5);

      // divide by zero
      wr(3'd0, 32'd42);
      wr(3'd1, 32'd42);
      wr(3'd3, 32'd1);
      rd(3'd3, q);  check("dz_status_t1", q, 32'h1);
      rd(3'd3, q);  check("dz_status_t2", q, 32'h6);
      rd(3'd2, q);  check("dz_result", q, 32'd42);
      rd(3'd4, q);  check("dz_quotient", q, QUO_DZ);
      wr(3'd3, 32'd2);
      rd(3'd3, q);  check("clear_status", q, 32'h0);

      // writes and restart while busy are ignored
      wr(3'd0, 32'd100);
      wr(3'd1, 32'd93);
      wr(3'd3, 32'd1);
      wr(3'd0, 32'd7);
      wr(3'd3, 32'd1);
      wait_idle(n, q);
      check("busy_lock_cycles", 32'(n), 32'd15);
      check("busy_lock_status", q, 32'h2);
      rd(3'd0, q);  check("busy_lock_x", q, 32'd100);
      rd(3'd2, q);  check("busy_lock_result", q, 32'd2);

      // read-only addresses, unmapped read, write-first, disabled block
      wr(3'd2, 32'd99);
      rd(3'd2, q);  check("result_ro", q, 32'd2);
      wr(3'd4, 32'd99);
      rd(3'd4, q);  check("quotient_ro", q, QUO_100_93);
      rd(3'd5, q);  check("addr5_zero", q, 32'd0);
      xfer(1'b1, 1'b1, 1'b1, 3'd0, 32'd55, q);
      check("write_first", q, 32'd55);
      xfer(1'b0, 1'b1, 1'b1, 3'd0, 32'd9, q);
      check("disabled_out_hold", q, 32'd55);
      rd(3'd0, q);  check("disabled_no_write", q, 32'd55);

      // reset in the middle of an operation
      wr(3'd0, 32'd100);
      wr(3'd3, 32'd1);
      for (int i = 0; i < 4; i++) rd(3'd3, q);
      check("pre_reset_busy", q, 32'h1);
      @(negedge CLK);
      RSTN = 1'b0;
      #1;
      check("async_reset_out", OUT, 32'd0);
      @(negedge CLK);
      RSTN = 1'b1;
      acc = '0;
      for (int i = 0; i < 25; i++) begin
         rd(3'd3, q);
         acc |= q;
      end
      check("no_done_after_reset", acc, 32'd0);
      rd(3'd0, q);  check("x_after_reset", q, 32'd0);
      rd(3'd2, q);  check("result_after_reset", q, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/xy_modulo_seq.md
XY_MODULO_SEQ -- requirements
Module: xy_modulo_seq

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width; legal range 2..32.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RSTN  input  1  asynchronous, active-low reset.
REQ-004 E  input  1  block enable; when 0, R and W have no effect.
REQ-005 W  input  1  write strobe, sampled at the rising edge of CLK.
REQ-006 R  input  1  read strobe, sampled at the rising edge of CLK.
REQ-007 ADDR  input  3  register select: 0=X, 1=Y, 2=RESULT, 3=CTRL/STATUS, 4=QUOTIENT.
REQ-008 D  input  WIDTH  write data.
REQ-009 OUT  output  32  registered read data, zero-extended from WIDTH.

Function
REQ-010 The block SHALL compute RESULT = X mod DIV, where DIV = (X - Y) truncated to WIDTH bits (wrap-around, unsigned).
REQ-011 A write to ADDR 0 or 1 SHALL load X or Y from D only when BUSY=0; while BUSY=1 such writes SHALL be ignored.
REQ-012 Writes to ADDR 2 and ADDR 4 SHALL be ignored.
REQ-013 A write to ADDR 3 with D[0]=1 and BUSY=0 SHALL start an operation; start while BUSY=1 SHALL be ignored.
REQ-014 A write to ADDR 3 with D[1]=1 SHALL clear DONE and DZ; start takes precedence if D[0]=1 in the same write.
REQ-015 FSM states: IDLE, LOAD, DIV. Start moves IDLE->LOAD. LOAD latches DIV and goes to DIV, or to IDLE if DIV=0. DIV runs exactly WIDTH restoring-division iterations (one quotient bit per cycle, MSB first), then goes to IDLE.
REQ-016 BUSY SHALL be 1 from the start edge t0 until the edge that returns the FSM to IDLE.
REQ-017 With DIV!=0, RESULT and DONE SHALL update at edge t0+1+WIDTH; BUSY clears at the same edge.
REQ-018 With DIV=0, at edge t0+1 the block SHALL set RESULT=X, DZ=1, DONE=1 and BUSY=0.
REQ-019 Start SHALL clear DONE and DZ at edge t0; RESULT SHALL hold its previous value until completion.
REQ-020 A read (R=1, E=1) SHALL load OUT at the edge with the register value. STATUS reads as {29'b0, DZ, DONE, BUSY}.
REQ-021 When R and W target the same address in the same cycle, OUT SHALL return the newly written value (write-first).
REQ-022 OUT SHALL hold its value when no read occurs; ADDR 5..7 SHALL read as 0.

Reset
REQ-023 RSTN=0 SHALL asynchronously force FSM=IDLE and clear X, Y, RESULT, quotient, DONE, DZ, BUSY and OUT to 0.
REQ-024 Reset asserted mid-operation SHALL abort it; after release the block SHALL be IDLE and no DONE is produced.

Configuration
REQ-025 Macro XYMOD_QUOTIENT_EN defined: the quotient X / DIV SHALL be stored at completion and readable at ADDR 4; on DIV=0 the quotient SHALL be all ones.
REQ-026 Macro XYMOD_QUOTIENT_EN undefined: no quotient register SHALL exist, and ADDR 4 SHALL read as 0.

Verification
REQ-027 WIDTH=16, X=100, Y=93, start: BUSY is high for 17 cycles, then DONE=1, RESULT reads 2, and STATUS reads 0x2.
REQ-028 X=5, Y=10 (DIV wraps to 65531), start: RESULT=5, DZ=0.
REQ-029 X=Y=42, start: one edge later DONE=1, DZ=1, RESULT=42, and STATUS reads 0x6.
REQ-030 During BUSY, write X=7 and issue a second start: X is unchanged, and the first result completes on its original cycle.
REQ-031 RSTN pulsed low at cycle 5 of an operation: all outputs are 0 immediately, and DONE never asserts.
REQ-032 With XYMOD_QUOTIENT_EN, X=100, Y=93: ADDR 4 reads 14. Without the macro, ADDR 4 reads 0.
